pipe_stage_buffer: RTL and testbench
====================================

// Module: pipe_stage_buffer
// PURPOSE
//   Two-entry valid/ready pipeline buffer (skid buffer) inserted between NPC stages (e.g. IF->ID, ID->EX).
//   Breaks the combinational ready path: in_ready depends only on registered state, never on out_ready.
//   Sustains one beat/cycle when unstalled, holds data losslessly under back-pressure, and supports flush.
//   Storage is built from regTemplate instances, one per state/data register.
// PARAMETERS
//   WIDTH      32  payload width in bits (>=1)
//   RESET_VAL  0   reset value of both payload registers (WIDTH bits)
// PORTS
//   clk        in   1      single clock; all state updates on posedge clk
//   rst        in   1      synchronous, active-high reset
//   flush      in   1      discard all held and incoming data (branch/exception redirect)
//   in_valid   in   1      upstream beat present
//   in_ready   out  1      buffer can accept a beat this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      out_data holds a valid beat
//   out_ready  in   1      downstream accepts the beat this cycle
//   out_data   out  WIDTH  payload of the oldest held beat (main register)
//   occupancy  out  2      beats held: 0, 1 or 2
// BEHAVIOUR
//   - Fire: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - State register (2 bits): EMPTY (0 beats), BUSY (main valid), FULL (main + skid valid).
//   - Combinational outputs from state only: in_ready = (state != FULL); out_valid = (state != EMPTY);
//     occupancy = 0/1/2 for EMPTY/BUSY/FULL; out_data = main_q.
//   - Priority per edge: rst > flush > normal transitions.
//   - rst=1: state <= EMPTY; main_q, skid_q <= RESET_VAL. Next cycle: out_valid=0, in_ready=1, occupancy=0.
//   - flush=1 (rst=0): state <= EMPTY; any in_fire that cycle is dropped; main_q/skid_q hold their values
//     (don't-care, since out_valid=0). out_fire may still occur in the flush cycle (downstream ignores it).
//   - EMPTY:  in_fire -> BUSY, main_q <= in_data.  else stay.
//   - BUSY:   in_fire & out_fire  -> BUSY, main_q <= in_data (zero-bubble pass-through).
//             in_fire & !out_fire -> FULL, skid_q <= in_data.
//             !in_fire & out_fire -> EMPTY.  neither -> stay.
//   - FULL:   in_ready=0, so in_fire impossible. out_fire -> BUSY, main_q <= skid_q. else stay.
//   - Latency: 1 cycle in_fire -> out_valid. Throughput: 1 beat/cycle with out_ready held high.
//   - Ordering strictly FIFO; no beat duplicated or lost except by flush/rst.
//   - out_data and out_valid stay stable while out_valid=1 & out_ready=0 (AXI-style hold rule).
//   - Illegal encoding (3): treated as EMPTY on the next edge; never reached from reset.
//   - Registers written only when needed (wen gated); no X propagation after reset.
// STRUCTURE
//   - Header pipe_defs.vh (shared by all pipeline buffers): `PSB_EMPTY 2'd0, `PSB_BUSY 2'd1,
//     `PSB_FULL 2'd2, `PSB_STW 2 (state width).
//   - Sub-module: regTemplate, three instances: state (2 bits, RESET_VAL=`PSB_EMPTY, wen=1),
//     main_q (WIDTH, wen=main load), skid_q (WIDTH, wen=skid load).
//   - Next-state and write enables in a single combinational always block; no other logic.
// TESTING
//   1 reset: rst high 2 cycles -> out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL.
//   2 stream: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on
//     cycles +1..+4, out_valid continuously 1, in_ready continuously 1.
//   3 back-pressure: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA held;
//     raise out_ready -> pops 0xA then 0xB, in_ready=1 the cycle after first pop.
//   4 simultaneous: BUSY with 0x5, in_fire 0x6 and out_fire same cycle -> state stays BUSY, out_data=0x6.
//   5 flush: FULL (0xA,0xB), flush=1 with in_valid=1 in_data=0xC -> next cycle out_valid=0,
//     occupancy=0; 0xC never appears on out_data.
//   6 reset mid-operation: FULL, rst=1 for 1 cycle with in_valid=1 -> EMPTY, in_ready=1, no beat out.
//   Scoreboard: random in_valid/out_ready/flush, reference FIFO model checks order and stability rules.

Source files
------------

// File: rtl/pipe_stage_buffer_pkg.sv
// rtl/pipe_stage_buffer_pkg.sv - shared state encodings and helpers for pipeline buffers
package pipe_stage_buffer_pkg;

  localparam int          PSB_STW   = 2;
  localparam logic [1:0]  PSB_EMPTY = 2'd0;
  localparam logic [1:0]  PSB_BUSY  = 2'd1;
  localparam logic [1:0]  PSB_FULL  = 2'd2;

  // Illegal encoding reports as empty; it is never reached from reset.
  function automatic logic [1:0] psb_occupancy(input logic [PSB_STW-1:0] st);
    case (st)
      PSB_BUSY: psb_occupancy = 2'd1;
      PSB_FULL: psb_occupancy = 2'd2;
      default:  psb_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buffer_reg_template.sv
// rtl/pipe_stage_buffer_reg_template.sv - write-enabled register with synchronous reset
module reg_template #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - two-entry skid buffer with registered ready and flush
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [PSB_STW-1:0] state_q;
  logic [PSB_STW-1:0] next_state;
  logic [WIDTH-1:0]   main_q;
  logic [WIDTH-1:0]   skid_q;
  logic [WIDTH-1:0]   main_d;
  logic               main_wen;
  logic               skid_wen;
  logic               in_fire;
  logic               out_fire;

  // Ready and valid come from registered state only, never from out_ready.
  assign in_ready  = (state_q != PSB_FULL);
  assign out_valid = (state_q != PSB_EMPTY);
  assign occupancy = psb_occupancy(state_q);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    next_state = state_q;
    main_wen   = 1'b0;
    skid_wen   = 1'b0;
    main_d     = in_data;
    if (flush) begin
      next_state = PSB_EMPTY;
    end else begin
      case (state_q)
        PSB_EMPTY: begin
          if (in_fire) begin
            next_state = PSB_BUSY;
            main_wen   = 1'b1;
          end
        end
        PSB_BUSY: begin
          case ({in_fire, out_fire})
            2'b11: main_wen = 1'b1;
            2'b10: begin
              next_state = PSB_FULL;
              skid_wen   = 1'b1;
            end
            2'b01: next_state = PSB_EMPTY;
            default: next_state = PSB_BUSY;
          endcase
        end
        PSB_FULL: begin
          if (out_fire) begin
            next_state = PSB_BUSY;
            main_wen   = 1'b1;
            main_d     = skid_q;
          end
        end
        default: next_state = PSB_EMPTY;
      endcase
    end
  end

  reg_template #(.WIDTH(PSB_STW), .RESET_VAL(PSB_EMPTY)) u_state (
    .clk (clk),
    .rst (rst),
    .wen (1'b1),
    .d   (next_state),
    .q   (state_q)
  );

  reg_template #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .wen (main_wen),
    .d   (main_d),
    .q   (main_q)
  );

  reg_template #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk (clk),
    .rst (rst),
    .wen (skid_wen),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb/tb_pipe_stage_buffer.sv - directed and scoreboard checks for pipe_stage_buffer
module tb_pipe_stage_buffer;

  localparam int          W   = 32;
  localparam logic [31:0] RV  = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;

  int total = 0;
  int bad   = 0;

  pipe_stage_buffer #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic expect_state(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    check({tag, ".occ"},       {30'd0, occupancy}, {30'd0, occ});
  endtask

  logic [31:0] model_q[$];
  logic        m_ir, m_ov;

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    expect_state("reset", 1'b0, 1'b1, 2'd0);
    check("reset.data", out_data, RV);
    rst = 1'b0;

    // stream 1..4 with zero bubbles
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      tick();
      check($sformatf("stream.data%0d", i), out_data, i);
      expect_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    expect_state("stream.drain", 1'b0, 1'b1, 2'd0);

    // back-pressure
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    tick();
    expect_state("bp.a", 1'b1, 1'b1, 2'd1);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    tick();
    expect_state("bp.b", 1'b1, 1'b0, 2'd2);
    check("bp.b.data", out_data, 32'hA);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("bp.hold.data", out_data, 32'hA);
    check("bp.hold.occ", {30'd0, occupancy}, 32'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("bp.pop1.data", out_data, 32'hB);
    expect_state("bp.pop1", 1'b1, 1'b1, 2'd1);
    tick();
    expect_state("bp.pop2", 1'b0, 1'b1, 2'd0);

    // simultaneous in/out fire in BUSY
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    tick();
    check("sim.first", out_data, 32'h5);
    drive(1'b1, 32'h6, 1'b1, 1'b0);
    tick();
    check("sim.data", out_data, 32'h6);
    expect_state("sim", 1'b1, 1'b1, 2'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    expect_state("sim.drain", 1'b0, 1'b1, 2'd0);

    // flush from FULL with incoming beat
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    tick();
    expect_state("fl.full", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 32'hC, 1'b0, 1'b1);
    tick();
    expect_state("fl.after", 1'b0, 1'b1, 2'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    expect_state("fl.idle", 1'b0, 1'b1, 2'd0);

    // flush drops an accepted beat from BUSY
    drive(1'b1, 32'hD, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hE, 1'b0, 1'b1);
    tick();
    expect_state("fl2.after", 1'b0, 1'b1, 2'd0);
    drive(1'b1, 32'hF, 1'b0, 1'b0);
    tick();
    check("fl2.next", out_data, 32'hF);
    expect_state("fl2.next", 1'b1, 1'b1, 2'd1);

    // reset mid-operation while FULL
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    expect_state("rm.full", 1'b1, 1'b0, 2'd2);
    rst = 1'b1;
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    expect_state("rm.after", 1'b0, 1'b1, 2'd0);
    check("rm.data", out_data, RV);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    expect_state("rm.idle", 1'b0, 1'b1, 2'd0);

    // random traffic against a reference FIFO
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      #1;
      m_ir = (model_q.size() < 2);
      m_ov = (model_q.size() > 0);
      check("rnd.in_ready",  {31'd0, in_ready},  {31'd0, m_ir});
      check("rnd.out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      check("rnd.occ", {30'd0, occupancy}, model_q.size());
      if (m_ov) check("rnd.data", out_data, model_q[0]);
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_ov && out_ready) void'(model_q.pop_front());
        if (m_ir && in_valid) model_q.push_back(in_data);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
